tcam_match_encoder: RTL and testbench

- Consumes the match-line vector from the TCAM lookup array, plus the search-valid/tag that the K-cycle delay line has aligned to it.
- Produces the lowest-index matching entry address, a hit flag and a multi-match flag.
- Results are buffered in a small output FIFO with a valid/ready handshake, because the upstream search pipeline cannot stall.
- An almost-full credit signal throttles new searches before the FIFO can overflow.

---
 rtl/tcam_match_encoder.sv | 189 ++++++++++++++++++
 tb/tb_tcam_match_encoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tcam_match_encoder.sv
// TCAM match-line priority encoder: two registered encode stages feeding a
// result FIFO with afull credit. Define MATCH_COUNT_EN to add the ocnt popcount output.
`default_nettype none

module tcam_match_encoder #(
  parameter int N   = 32,
  parameter int SEG = 8,
  parameter int AW  = 5,
  parameter int TW  = 8,
  parameter int FD  = 8,
  parameter int K   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mvld,
  input  logic [N-1:0]  mline,
  input  logic [TW-1:0] itag,
  output logic          ovld,
  input  logic          ordy,
  output logic          ohit,
  output logic [AW-1:0] oaddr,
  output logic          omulti,
  output logic [TW-1:0] otag,
`ifdef MATCH_COUNT_EN
  output logic [AW:0]   ocnt,
`endif
  output logic          afull,
  output logic          ovf
);

  localparam int NS  = N / SEG;
  localparam int SAW = $clog2(SEG);
  localparam int FAW = $clog2(FD);

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] addr;
    logic          multi;
    logic [TW-1:0] tag;
`ifdef MATCH_COUNT_EN
    logic [AW:0]   cnt;
`endif
  } res_t;

  // stage 1: per-segment encode
  logic [SEG-1:0] seg;
  logic [NS-1:0]  c_hit;
  logic [NS-1:0]  c_multi;
  logic [SAW-1:0] c_idx [NS];
`ifdef MATCH_COUNT_EN
  logic [SAW:0]   c_cnt [NS];
`endif

  always_comb begin
    seg = '0;
    for (int s = 0; s < NS; s++) begin
      seg        = mline[s*SEG +: SEG];
      c_hit[s]   = |seg;
      // clearing the lowest set bit leaves something only when two or more were set
      c_multi[s] = |(seg & (seg - SEG'(1)));
      c_idx[s]   = '0;
      for (int b = SEG - 1; b >= 0; b--) begin
        if (seg[b]) c_idx[s] = SAW'(b);
      end
`ifdef MATCH_COUNT_EN
      c_cnt[s] = '0;
      for (int b = 0; b < SEG; b++) begin
        c_cnt[s] = c_cnt[s] + (SAW+1)'(seg[b]);
      end
`endif
    end
  end

  logic           s1_vld;
  logic [TW-1:0]  s1_tag;
  logic [NS-1:0]  s1_hit;
  logic [NS-1:0]  s1_multi;
  logic [SAW-1:0] s1_idx [NS];
`ifdef MATCH_COUNT_EN
  logic [SAW:0]   s1_cnt [NS];
`endif

  always_ff @(posedge clk) begin
    if (!rst) s1_vld <= 1'b0;
    else      s1_vld <= mvld;
  end

  always_ff @(posedge clk) begin
    if (mvld) begin
      s1_tag   <= itag;
      s1_hit   <= c_hit;
      s1_multi <= c_multi;
      s1_idx   <= c_idx;
`ifdef MATCH_COUNT_EN
      s1_cnt   <= c_cnt;
`endif
    end
  end

  // stage 2: pick the lowest hitting segment
  res_t n_res;
  logic higher;

  always_comb begin
    n_res     = '0;
    n_res.tag = s1_tag;
    higher    = 1'b0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (s1_hit[s]) begin
        n_res.hit   = 1'b1;
        n_res.addr  = AW'(s * SEG) | AW'(s1_idx[s]);
        n_res.multi = s1_multi[s] | higher;
      end
      higher = higher | s1_hit[s];
    end
`ifdef MATCH_COUNT_EN
    for (int s = 0; s < NS; s++) begin
      n_res.cnt = n_res.cnt + (AW+1)'(s1_cnt[s]);
    end
`endif
  end

  logic s2_vld;
  res_t s2_res;

  always_ff @(posedge clk) begin
    if (!rst) s2_vld <= 1'b0;
    else      s2_vld <= s1_vld;
  end

  always_ff @(posedge clk) begin
    if (s1_vld) s2_res <= n_res;
  end

  // result FIFO
  res_t           mem [FD];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FAW:0]   occ;
  logic           full;
  logic           rd_en;
  logic           wr_en;
  logic [FAW+1:0] credit;
  res_t           head;

  assign full   = (occ == (FAW+1)'(FD));
  assign ovld   = (occ != '0);
  assign rd_en  = ovld & ordy;
  // a read in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en  = s2_vld & (~full | rd_en);
  assign credit = (FAW+2)'(occ) + (FAW+2)'(s1_vld) + (FAW+2)'(s2_vld);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s2_res;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
      afull  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FAW'(1);
      if (rd_en) rd_ptr <= rd_ptr + FAW'(1);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + (FAW+1)'(1);
        2'b01:   occ <= occ - (FAW+1)'(1);
        default: occ <= occ;
      endcase
      if (s2_vld && full && !rd_en) ovf <= 1'b1;
      afull <= (credit >= (FAW+2)'(FD - K));
    end
  end

  // head fields read 0 whenever nothing is buffered, including just after reset
  assign head   = ovld ? mem[rd_ptr] : '0;
  assign ohit   = head.hit;
  assign oaddr  = head.addr;
  assign omulti = head.multi;
  assign otag   = head.tag;
`ifdef MATCH_COUNT_EN
  assign ocnt   = head.cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tcam_match_encoder.sv
// Bench for tcam_match_encoder: directed steps plus random traffic against a
// queue-based reference model of the encoder, FIFO, afull credit and ovf.
module tb_tcam_match_encoder;
  localparam int N   = 32;
  localparam int SEG = 8;
  localparam int AW  = 5;
  localparam int TW  = 8;
  localparam int FD  = 8;
  localparam int K   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mvld = 1'b0;
  logic [N-1:0]  mline = '0;
  logic [TW-1:0] itag = '0;
  logic          ordy = 1'b0;
  logic          ovld, ohit, omulti, afull, ovf;
  logic [AW-1:0] oaddr;
  logic [TW-1:0] otag;
`ifdef MATCH_COUNT_EN
  logic [AW:0]   ocnt;
`endif

  tcam_match_encoder #(.N(N), .SEG(SEG), .AW(AW), .TW(TW), .FD(FD), .K(K)) dut (
    .clk(clk), .rst(rst), .mvld(mvld), .mline(mline), .itag(itag),
    .ovld(ovld), .ordy(ordy), .ohit(ohit), .oaddr(oaddr), .omulti(omulti),
    .otag(otag),
`ifdef MATCH_COUNT_EN
    .ocnt(ocnt),
`endif
    .afull(afull), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] addr;
    logic          multi;
    logic [TW-1:0] tag;
    logic [AW:0]   cnt;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  res_t m_fifo[$];
  res_t p1, p2;
  bit   p1v = 0, p2v = 0;
  bit   m_ovf = 0, m_afull = 0;

  function automatic res_t encode(input logic [N-1:0] ml, input logic [TW-1:0] tg);
    res_t r;
    r       = '0;
    r.tag   = tg;
    r.cnt   = (AW+1)'($countones(ml));
    r.hit   = (ml != '0);
    r.multi = ($countones(ml) > 1);
    for (int i = N - 1; i >= 0; i--) if (ml[i]) r.addr = AW'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [N-1:0] ml, input logic [TW-1:0] tg,
                            input bit rd_ok, input bit rs);
    bit rd;
    if (!rs) begin
      m_fifo.delete();
      p1v = 0; p2v = 0; m_ovf = 0; m_afull = 0;
    end else begin
      rd = (m_fifo.size() > 0) && rd_ok;
      m_afull = ((m_fifo.size() + int'(p1v) + int'(p2v)) >= FD - K);
      if (rd) void'(m_fifo.pop_front());
      if (p2v) begin
        if (m_fifo.size() < FD) m_fifo.push_back(p2);
        else m_ovf = 1;
      end
      p2v = p1v; p2 = p1;
      p1v = v;   p1 = encode(ml, tg);
    end
  endtask

  task automatic compare();
    chk("ovld", ovld, m_fifo.size() > 0);
    chk("afull", afull, m_afull);
    chk("ovf", ovf, m_ovf);
    if (m_fifo.size() > 0) begin
      chk("ohit", ohit, m_fifo[0].hit);
      chk("oaddr", oaddr, m_fifo[0].addr);
      chk("omulti", omulti, m_fifo[0].multi);
      chk("otag", otag, m_fifo[0].tag);
`ifdef MATCH_COUNT_EN
      chk("ocnt", ocnt, m_fifo[0].cnt);
`endif
    end
  endtask

  task automatic step(input bit v, input logic [N-1:0] ml, input logic [TW-1:0] tg,
                      input bit rd_ok, input bit rs);
    mvld = v; mline = ml; itag = tg; ordy = rd_ok; rst = rs;
    @(posedge clk);
    model_edge(v, ml, tg, rd_ok, rs);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input bit rd_ok);
    for (int i = 0; i < n; i++) step(0, '0, '0, rd_ok, 1);
  endtask

  task automatic zero_fields(input string tag);
    chk({tag, "_ohit"}, ohit, 0);
    chk({tag, "_oaddr"}, oaddr, 0);
    chk({tag, "_omulti"}, omulti, 0);
    chk({tag, "_otag"}, otag, 0);
`ifdef MATCH_COUNT_EN
    chk({tag, "_ocnt"}, ocnt, 0);
`endif
  endtask

  initial begin
    logic [N-1:0] ml;
    @(negedge clk);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
    zero_fields("reset");

    // single match at 17: ovld two edges after mvld, held for one cycle
    step(1, N'(1) << 17, 8'hA1, 1, 1);
    step(0, '0, '0, 1, 1);
    chk("lat_pre_ovld", ovld, 0);
    step(0, '0, '0, 1, 1);
    chk("lat_ovld", ovld, 1);
    chk("lat_addr17", oaddr, 17);
    chk("lat_tag", otag, 8'hA1);
    idle(2, 1);

    // no match, then multi-match cases
    step(1, '0, 8'h22, 1, 1);
    step(1, (N'(1) << 3) | (N'(1) << 30), 8'h33, 1, 1);
    step(1, (N'(1) << 8) | (N'(1) << 9), 8'h44, 1, 1);
    idle(4, 1);

    // back-pressure: 10 searches into an 8-deep FIFO drops two
    for (int i = 0; i < 10; i++) step(1, N'(1) << i, TW'(8'h50 + i), 0, 1);
    idle(3, 0);
    chk("ovf_after_flood", ovf, 1);
    chk("afull_after_flood", afull, 1);
    idle(10, 1);
    chk("drained", ovld, 0);

    // full FIFO with simultaneous read and write keeps occupancy, no drop
    step(0, '0, '0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, N'(1) << (i + 20), TW'(8'h60 + i), 0, 1);
    idle(2, 0);
    for (int i = 0; i < 6; i++) step(1, N'(1) << i, TW'(8'h70 + i), 1, 1);
    chk("full_rw_no_ovf", ovf, 0);
    idle(12, 1);

    // reset with 5 buffered and 2 in flight
    for (int i = 0; i < 7; i++) step(1, N'(1) << (i + 1), TW'(8'h80 + i), 0, 1);
    step(0, '0, '0, 0, 0);
    chk("rst_mid_ovld", ovld, 0);
    chk("rst_mid_afull", afull, 0);
    zero_fields("rst_mid");
    idle(5, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: ml = '0;
        1: ml = N'(1) << $urandom_range(N - 1);
        2: ml = N'($urandom);
        default: ml = N'($urandom & $urandom & $urandom);
      endcase
      step(bit'($urandom_range(1)), ml, TW'($urandom),
           $urandom_range(3) != 0, $urandom_range(99) != 0);
    end
    idle(12, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
